// File: rtl/pwm_capture.sv
// Measures per-channel high time over a free-running 2**pwm_width window and reports
// saturated duty words plus update strobe, stability and overrange flags.
module pwm_capture #(
  parameter int pwm_width   = 3,
  parameter int num_pwm     = 4,
  parameter int sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [num_pwm-1:0]   pwm_in,
  output logic [pwm_width-1:0] duty [num_pwm-1:0],
  output logic                 upd,
  output logic [num_pwm-1:0]   stable,
  output logic [num_pwm-1:0]   ovr
);

  localparam logic [pwm_width:0] FULL = {1'b1, {pwm_width{1'b0}}};

  logic [num_pwm-1:0]   s;
  logic [pwm_width-1:0] win_q;
  logic                 win_end;
  logic [pwm_width:0]   acc_q  [num_pwm-1:0];
  logic [pwm_width:0]   prev_q [num_pwm-1:0];
  logic [pwm_width:0]   cnt_d  [num_pwm-1:0];
  logic [pwm_width-1:0] duty_q [num_pwm-1:0];
  logic                 upd_q;
  logic [num_pwm-1:0]   stable_q;
  logic [num_pwm-1:0]   ovr_q;

  generate
    if (sync_stages == 0) begin : g_nosync
      assign s = pwm_in;
    end else begin : g_sync
      logic [num_pwm-1:0] sync_q [sync_stages];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < sync_stages; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= pwm_in;
          for (int k = 1; k < sync_stages; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[sync_stages-1];
    end
  endgenerate

  assign win_end = (win_q == {pwm_width{1'b1}});

  // Window total including the sample taken on the window-end cycle itself.
  always_comb begin
    for (int i = 0; i < num_pwm; i++) begin
      cnt_d[i] = acc_q[i] + {{pwm_width{1'b0}}, s[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q    <= '0;
      upd_q    <= 1'b0;
      stable_q <= '0;
      ovr_q    <= '0;
      for (int i = 0; i < num_pwm; i++) begin
        acc_q[i]  <= '0;
        prev_q[i] <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      win_q <= win_q + 1'b1;
      upd_q <= win_end;
      for (int i = 0; i < num_pwm; i++) begin
        if (win_end) begin
          duty_q[i]   <= (cnt_d[i] == FULL) ? {pwm_width{1'b1}} : cnt_d[i][pwm_width-1:0];
          ovr_q[i]    <= (cnt_d[i] == FULL);
          stable_q[i] <= (cnt_d[i] != FULL) && (cnt_d[i] == prev_q[i]);
          prev_q[i]   <= cnt_d[i];
          acc_q[i]    <= '0;
        end else begin
          acc_q[i] <= cnt_d[i];
        end
      end
    end
  end

  assign duty   = duty_q;
  assign upd    = upd_q;
  assign stable = stable_q;
  assign ovr    = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a PWM source model drives a sync_stages=2 instance,
// a one-pulse-per-period source drives a sync_stages=0 instance.
module tb_pwm_capture;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic [3:0] pwm_in, pwm_in0;
  logic [2:0] duty  [3:0];
  logic [2:0] duty0 [3:0];
  logic       upd, upd0;
  logic [3:0] stable, ovr, stable0, ovr0;

  pwm_capture #(.pwm_width(3), .num_pwm(4), .sync_stages(2)) u_dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty), .upd(upd), .stable(stable), .ovr(ovr));

  pwm_capture #(.pwm_width(3), .num_pwm(4), .sync_stages(0)) u_dut0 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in0), .duty(duty0), .upd(upd0), .stable(stable0), .ovr(ovr0));

  int total = 0;
  int bad   = 0;

  // Source model: period-8 PWM, threshold latched at period start, optional force masks.
  int               cyc;
  int               phase;
  logic [3:0][2:0]  thres_cur, thres_nxt;
  logic [3:0]       hi, lo;

  typedef struct {
    logic [3:0][2:0] thres;
    logic [3:0]      hi;
    logic [3:0]      lo;
    logic [3:0][2:0] e_duty;
    logic [3:0]      e_ovr;
    logic [3:0]      e_stable;
  } vec_t;

  vec_t tv [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    int pos;
    pos = (cyc + phase) % 8;
    if (pos == 0) thres_cur = thres_nxt;
    for (int i = 0; i < 4; i++) begin
      pwm_in[i] = hi[i] | (~lo[i] & (pos < int'(thres_cur[i])));
    end
    pwm_in0 = {4{pos == 0}};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    cyc = 0;
    drive();
  endtask

  // Steps until the selected instance strobes upd; n is the number of cycles taken.
  task automatic wait_upd(input bit sel0, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(sel0 ? upd0 : upd) && n < 64);
    if (!(sel0 ? upd0 : upd)) chk("upd_timeout", n, -1);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 4; i++) chk({tag, "_duty"}, int'(duty[i]), 0);
    chk({tag, "_upd"}, int'(upd), 0);
    chk({tag, "_stable"}, int'(stable), 0);
    chk({tag, "_ovr"}, int'(ovr), 0);
  endtask

  initial begin
    int n;
    int v;

    tv[0] = '{{3'd0,3'd0,3'd0,3'd0}, 4'b0000, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 4'b0000, 4'b1111};
    tv[1] = '{{3'd2,3'd4,3'd7,3'd1}, 4'b0000, 4'b0000, {3'd2,3'd4,3'd7,3'd1}, 4'b0000, 4'b1111};
    tv[2] = '{{3'd6,3'd3,3'd5,3'd0}, 4'b0000, 4'b0000, {3'd6,3'd3,3'd5,3'd0}, 4'b0000, 4'b1111};
    tv[3] = '{{3'd3,3'd5,3'd6,3'd2}, 4'b0001, 4'b0010, {3'd3,3'd5,3'd0,3'd7}, 4'b0001, 4'b1110};

    rst = 1'b0; cyc = 0; phase = 0;
    thres_cur = '0; thres_nxt = '0; hi = '0; lo = '0;
    drive();
    repeat (3) step();
    chk_all_zero("reset");
    chk("reset_upd0", int'(upd0), 0);

    rst = 1'b1;
    cyc = 0;
    drive();
    wait_upd(1'b0, n);
    chk("first_upd_latency", n, 8);
    step();
    chk("upd_one_cycle", int'(upd), 0);

    // Steady-state vectors: each settles over three windows, checked on the fourth.
    for (int k = 0; k < 4; k++) begin
      thres_nxt = tv[k].thres;
      hi = tv[k].hi;
      lo = tv[k].lo;
      repeat (4) wait_upd(1'b0, n);
      for (int i = 0; i < 4; i++) chk($sformatf("vec%0d_duty%0d", k, i), int'(duty[i]), int'(tv[k].e_duty[i]));
      chk($sformatf("vec%0d_ovr", k), int'(ovr), int'(tv[k].e_ovr));
      chk($sformatf("vec%0d_stable", k), int'(stable), int'(tv[k].e_stable));
    end

    // Forced lines right after reset: low line stable from second upd, high line never.
    hi = 4'b0001; lo = 4'b0010;
    do_reset();
    wait_upd(1'b0, n);
    wait_upd(1'b0, n);
    chk("force_duty0", int'(duty[0]), 7);
    chk("force_ovr0", int'(ovr[0]), 1);
    chk("force_stable0", int'(stable[0]), 0);
    chk("force_duty1", int'(duty[1]), 0);
    chk("force_stable1", int'(stable[1]), 1);
    hi = '0; lo = '0;

    // 4-high/4-low source at every phase offset.
    for (int p = 0; p < 8; p++) begin
      phase = p;
      thres_nxt = {3'd1, 3'd4, 3'd3, 3'd5};
      thres_cur = thres_nxt;
      do_reset();
      wait_upd(1'b0, n);
      wait_upd(1'b0, n);
      chk($sformatf("phase%0d_w2_duty2", p), int'(duty[2]), 4);
      wait_upd(1'b0, n);
      chk($sformatf("phase%0d_w3_duty2", p), int'(duty[2]), 4);
    end

    // Mid-window threshold change on channel 3: new period starts at window offset 4.
    phase = 6;
    thres_nxt = {3'd2, 3'd4, 3'd7, 3'd1};
    thres_cur = thres_nxt;
    do_reset();
    repeat (3) wait_upd(1'b0, n);
    chk("chg_pre_duty3", int'(duty[3]), 2);
    chk("chg_pre_stable3", int'(stable[3]), 1);
    thres_nxt[3] = 3'd6;
    wait_upd(1'b0, n);
    v = int'(duty[3]);
    chk("chg_partial_in_range", int'(v >= 2 && v <= 6), 1);
    chk("chg_partial_stable3", int'(stable[3]), 0);
    wait_upd(1'b0, n);
    chk("chg_full_duty3", int'(duty[3]), 6);
    chk("chg_full_stable3", int'(stable[3]), 0);
    wait_upd(1'b0, n);
    chk("chg_settled_duty3", int'(duty[3]), 6);
    chk("chg_settled_stable3", int'(stable[3]), 1);

    // Reset pulse at win==5 with every line high.
    phase = 0;
    hi = 4'b1111;
    do_reset();
    wait_upd(1'b0, n);
    wait_upd(1'b0, n);
    repeat (5) step();
    rst = 1'b0;
    step();
    chk_all_zero("midrst");
    rst = 1'b1;
    cyc = 0;
    drive();
    wait_upd(1'b0, n);
    chk("midrst_first_upd", n, 8);
    wait_upd(1'b0, n);
    chk("midrst_upd_period", n, 8);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_duty%0d", i), int'(duty[i]), 7);
    chk("midrst_ovr", int'(ovr), 15);
    chk("midrst_stable", int'(stable), 0);
    hi = '0;

    // Unsynchronized instance, one high cycle per period.
    do_reset();
    wait_upd(1'b1, n);
    wait_upd(1'b1, n);
    chk("sync0_upd_period", n, 8);
    for (int i = 0; i < 4; i++) chk($sformatf("sync0_duty%0d", i), int'(duty0[i]), 1);
    chk("sync0_ovr", int'(ovr0), 0);
    wait_upd(1'b1, n);
    chk("sync0_upd_period2", n, 8);
    chk("sync0_stable", int'(stable0), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
